// File: rtl/sound_gain_mixer.sv
// Time-multiplexed N-channel sound mixer: one multiply-accumulate per channel per cycle,
// followed by a floor shift and a saturating clamp, with sticky clip/overrun status.
module sound_gain_mixer #(
   parameter int unsigned COUNT      = 4,
   parameter int unsigned IN_WIDTH   = 10,
   parameter int unsigned OUT_WIDTH  = 10,
   parameter int unsigned GAIN_WIDTH = 8,
   parameter int unsigned GAIN_SHIFT = 6
) (
   input  logic                                     CLK,
   input  logic                                     RESET,
   input  logic                                     SAMPLE_EN,
   input  logic [COUNT*IN_WIDTH-1:0]                IN,
   input  logic [COUNT-1:0]                         MUTE,
   input  logic                                     GAIN_WE,
   input  logic [((COUNT > 1) ? $clog2(COUNT) : 1)-1:0] GAIN_CH,
   input  logic [GAIN_WIDTH-1:0]                    GAIN_DATA,
   input  logic                                     STATUS_CLR,
   output logic                                     BUSY,
   output logic signed [OUT_WIDTH-1:0]              OUT,
   output logic                                     OUT_VALID,
   output logic                                     CLIP,
   output logic                                     OVERRUN
);

   localparam int unsigned CH_W   = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam int unsigned PROD_W = IN_WIDTH + GAIN_WIDTH + 1;
   localparam int unsigned ACC_W  = PROD_W + $clog2(COUNT + 1);
   localparam int unsigned SAT_W  = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;

   localparam logic [GAIN_WIDTH-1:0] GAIN_UNITY = GAIN_WIDTH'(32'd1 << GAIN_SHIFT);
   localparam logic signed [SAT_W-1:0] SAT_MAX =
      {{(SAT_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
   localparam logic signed [SAT_W-1:0] SAT_MIN =
      {{(SAT_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_SAT  = 2'd2
   } state_t;

   state_t                      state_q, state_d;
   logic [CH_W-1:0]             ch_q, ch_d;
   logic signed [ACC_W-1:0]     acc_q, acc_d;
   logic signed [IN_WIDTH-1:0]  in_s_q [COUNT];
   logic signed [IN_WIDTH-1:0]  in_s_d [COUNT];
   logic [COUNT-1:0]            mute_s_q, mute_s_d;
   logic [GAIN_WIDTH-1:0]       gain_q [COUNT];
   logic [GAIN_WIDTH-1:0]       gain_d [COUNT];
   logic signed [OUT_WIDTH-1:0] out_q, out_d;
   logic                        out_valid_q, out_valid_d;
   logic                        busy_q, busy_d;
   logic                        clip_q, clip_d;
   logic                        overrun_q, overrun_d;

   logic signed [PROD_W-1:0]    prod_c;
   logic signed [ACC_W-1:0]     shifted_c;
   logic signed [SAT_W-1:0]     wide_c;
   logic signed [OUT_WIDTH-1:0] clamp_c;
   logic                        sat_hit_c;

   // Current channel's weighted contribution; gain is unsigned so it gets a zero sign bit.
   always_comb begin
      prod_c = PROD_W'(in_s_q[ch_q]) * PROD_W'($signed({1'b0, gain_q[ch_q]}));
      if (mute_s_q[ch_q]) begin
         prod_c = '0;
      end
   end

   // Floor shift of the accumulator and saturation to the output range.
   always_comb begin
      shifted_c = acc_q >>> GAIN_SHIFT;
      wide_c    = SAT_W'(shifted_c);
      sat_hit_c = 1'b0;
      clamp_c   = wide_c[OUT_WIDTH-1:0];
      if (wide_c > SAT_MAX) begin
         clamp_c   = SAT_MAX[OUT_WIDTH-1:0];
         sat_hit_c = 1'b1;
      end else if (wide_c < SAT_MIN) begin
         clamp_c   = SAT_MIN[OUT_WIDTH-1:0];
         sat_hit_c = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      acc_d       = acc_q;
      in_s_d      = in_s_q;
      mute_s_d    = mute_s_q;
      gain_d      = gain_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      busy_d      = busy_q;
      clip_d      = clip_q & ~STATUS_CLR;
      overrun_d   = overrun_q & ~STATUS_CLR;

      // Writes land on the edge, so an ACC read of the same channel still sees the old gain.
      for (int i = 0; i < COUNT; i++) begin
         if (GAIN_WE && (GAIN_CH == CH_W'(i))) begin
            gain_d[i] = GAIN_DATA;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (SAMPLE_EN) begin
               for (int i = 0; i < COUNT; i++) begin
                  in_s_d[i] = IN[i*IN_WIDTH +: IN_WIDTH];
               end
               mute_s_d = MUTE;
               acc_d    = '0;
               ch_d     = '0;
               busy_d   = 1'b1;
               state_d  = ST_ACC;
            end
         end
         ST_ACC: begin
            acc_d = acc_q + ACC_W'(prod_c);
            if (ch_q == CH_W'(COUNT - 1)) begin
               state_d = ST_SAT;
            end else begin
               ch_d = ch_q + CH_W'(1);
            end
            if (SAMPLE_EN) begin
               overrun_d = 1'b1;
            end
         end
         ST_SAT: begin
            out_d       = clamp_c;
            out_valid_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
            if (sat_hit_c) begin
               clip_d = 1'b1;
            end
            if (SAMPLE_EN) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         ch_q        <= '0;
         acc_q       <= '0;
         mute_s_q    <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         clip_q      <= 1'b0;
         overrun_q   <= 1'b0;
         for (int i = 0; i < COUNT; i++) begin
            in_s_q[i] <= '0;
            gain_q[i] <= GAIN_UNITY;
         end
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         acc_q       <= acc_d;
         in_s_q      <= in_s_d;
         mute_s_q    <= mute_s_d;
         gain_q      <= gain_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         clip_q      <= clip_d;
         overrun_q   <= overrun_d;
      end
   end

   assign BUSY      = busy_q;
   assign OUT       = out_q;
   assign OUT_VALID = out_valid_q;
   assign CLIP      = clip_q;
   assign OVERRUN   = overrun_q;

endmodule
